// File: rtl/sata_link_write_arbiter_pkg.sv
// Shared definitions for the SATA link write arbiter.
// Holds the FSM state encoding and the requester-index constants.
package sata_link_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ESCAPE = 2'd3
    } arb_state_t;

    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;

    localparam int unsigned RETRY_W = 3;

endpackage

// File: rtl/sata_link_write_arbiter.sv
// SATA link write arbiter: shares the link write path between a command
// FIS requester (r0) and a data FIS requester (r1) with round-robin choice.
// Ports: clk/rst (async, active-high); rN_req/size/data in, rN_grant/
// strobe/rewind/done/error out; lnk_write_* to/from the link write layer;
// lnk_sync_escape out; busy out.
// Option: define SATA_WR_ARB_RETRY_EN to retry frames on lnk_xmit_error.
module sata_link_write_arbiter
    import sata_link_write_arbiter_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned MAX_SIZE       = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic [31:0] r0_size,
    input  logic [31:0] r0_data,
    output logic        r0_grant,
    output logic        r0_strobe,
    output logic        r0_rewind,
    output logic        r0_done,
    output logic        r0_error,
    input  logic        r1_req,
    input  logic [31:0] r1_size,
    input  logic [31:0] r1_data,
    output logic        r1_grant,
    output logic        r1_strobe,
    output logic        r1_rewind,
    output logic        r1_done,
    output logic        r1_error,
    output logic        lnk_write_start,
    output logic [31:0] lnk_write_size,
    output logic [31:0] lnk_write_data,
    input  logic        lnk_write_strobe,
    input  logic        lnk_write_finished,
    input  logic        lnk_xmit_error,
    input  logic        lnk_idle,
    output logic        lnk_sync_escape,
    output logic        busy
);

    arb_state_t  state_q;
    logic [1:0]  grant_q;
    logic        cur_q;
    logic        last_q;
    logic [31:0] size_q;
    logic [31:0] timer_q;
    logic        start_q;
    logic [1:0]  done_q;
    logic [1:0]  error_q;
    logic        escape_q;
    logic        abort_q;

`ifdef SATA_WR_ARB_RETRY_EN
    localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] retry_q;
    logic [1:0]         rewind_q;
`endif

    // Requester not granted last wins a collision.
    function automatic logic rr_pick(input logic req0,
                                     input logic req1,
                                     input logic last);
        if (req0 && req1)
            return ~last;
        if (req1)
            return REQ_R1;
        return REQ_R0;
    endfunction

    // A requester whose done is showing still holds req for that cycle;
    // masking it keeps the same frame from being sampled twice.
    logic        req0_v;
    logic        req1_v;
    logic        pick;
    logic [31:0] pick_size;
    logic        size_ok;
    logic        cur_req;
    logic [31:0] timer_nxt;

    assign req0_v    = r0_req & ~done_q[0];
    assign req1_v    = r1_req & ~done_q[1];
    assign pick      = rr_pick(req0_v, req1_v, last_q);
    assign pick_size = pick ? r1_size : r0_size;
    assign size_ok   = (pick_size != 32'd0) &&
                       (pick_size <= 32'(MAX_SIZE));
    assign cur_req   = cur_q ? r1_req : r0_req;
    assign timer_nxt = (timer_q == '1) ? timer_q : timer_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'b00;
            cur_q    <= REQ_R0;
            last_q   <= REQ_R1;
            size_q   <= 32'd0;
            timer_q  <= 32'd0;
            start_q  <= 1'b0;
            done_q   <= 2'b00;
            error_q  <= 2'b00;
            escape_q <= 1'b0;
            abort_q  <= 1'b0;
`ifdef SATA_WR_ARB_RETRY_EN
            retry_q  <= '0;
            rewind_q <= 2'b00;
`endif
        end else begin
            start_q  <= 1'b0;
            done_q   <= 2'b00;
            error_q  <= 2'b00;
            escape_q <= 1'b0;
`ifdef SATA_WR_ARB_RETRY_EN
            rewind_q <= 2'b00;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (lnk_idle && (req0_v || req1_v)) begin
                        if (size_ok) begin
                            grant_q <= pick ? 2'b10 : 2'b01;
                            cur_q   <= pick;
                            last_q  <= pick;
                            size_q  <= pick_size;
                            start_q <= 1'b1;
                            abort_q <= 1'b0;
`ifdef SATA_WR_ARB_RETRY_EN
                            retry_q <= '0;
`endif
                            state_q <= ST_START;
                        end else begin
                            // Illegal size: reject without touching the link.
                            done_q[pick]  <= 1'b1;
                            error_q[pick] <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    timer_q <= 32'd0;
                    state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    timer_q <= timer_nxt;
                    if (lnk_write_finished) begin
                        if (!lnk_xmit_error) begin
                            done_q[cur_q] <= 1'b1;
                            grant_q       <= 2'b00;
                            state_q       <= ST_IDLE;
                        end else begin
`ifdef SATA_WR_ARB_RETRY_EN
                            if (retry_q < MAX_RETRY_V) begin
                                retry_q         <= retry_q + 1'b1;
                                rewind_q[cur_q] <= 1'b1;
                                start_q         <= 1'b1;
                                state_q         <= ST_START;
                            end else begin
                                done_q[cur_q]  <= 1'b1;
                                error_q[cur_q] <= 1'b1;
                                grant_q        <= 2'b00;
                                state_q        <= ST_IDLE;
                            end
`else
                            done_q[cur_q]  <= 1'b1;
                            error_q[cur_q] <= 1'b1;
                            grant_q        <= 2'b00;
                            state_q        <= ST_IDLE;
`endif
                        end
                    end else if (!cur_req) begin
                        // Owner withdrew: abort the frame, no done.
                        escape_q <= 1'b1;
                        abort_q  <= 1'b1;
                        state_q  <= ST_ESCAPE;
                    end else if (timer_nxt >= TIMEOUT_CYCLES) begin
                        escape_q <= 1'b1;
                        state_q  <= ST_ESCAPE;
                    end
                end
                ST_ESCAPE: begin
                    if (lnk_idle) begin
                        if (!abort_q) begin
                            done_q[cur_q]  <= 1'b1;
                            error_q[cur_q] <= 1'b1;
                        end
                        grant_q <= 2'b00;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign r0_grant  = grant_q[0];
    assign r1_grant  = grant_q[1];
    assign r0_strobe = lnk_write_strobe & grant_q[0] &
                       (state_q == ST_ACTIVE);
    assign r1_strobe = lnk_write_strobe & grant_q[1] &
                       (state_q == ST_ACTIVE);
    assign r0_done   = done_q[0];
    assign r1_done   = done_q[1];
    assign r0_error  = error_q[0];
    assign r1_error  = error_q[1];

`ifdef SATA_WR_ARB_RETRY_EN
    assign r0_rewind = rewind_q[0];
    assign r1_rewind = rewind_q[1];
`else
    assign r0_rewind = 1'b0;
    assign r1_rewind = 1'b0;
`endif

    assign lnk_write_start = start_q;
    assign lnk_write_size  = size_q;
    assign lnk_write_data  = grant_q[1] ? r1_data :
                             grant_q[0] ? r0_data : 32'd0;
    assign lnk_sync_escape = escape_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sata_link_write_arbiter.sv
// Directed bench for sata_link_write_arbiter.
// Drives link-layer status by hand and checks each step.
module tb_sata_link_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0;
    logic [31:0] r0_size = 32'd0;
    logic [31:0] r0_data = 32'h0;
    logic        r0_grant, r0_strobe, r0_rewind, r0_done, r0_error;
    logic        r1_req = 1'b0;
    logic [31:0] r1_size = 32'd0;
    logic [31:0] r1_data = 32'h0;
    logic        r1_grant, r1_strobe, r1_rewind, r1_done, r1_error;
    logic        lnk_write_start;
    logic [31:0] lnk_write_size;
    logic [31:0] lnk_write_data;
    logic        lnk_write_strobe = 1'b0;
    logic        lnk_write_finished = 1'b0;
    logic        lnk_xmit_error = 1'b0;
    logic        lnk_idle = 1'b1;
    logic        lnk_sync_escape;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sata_link_write_arbiter #(
        .TIMEOUT_CYCLES(32'd100),
        .MAX_RETRY(2),
        .MAX_SIZE(2048)
    ) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_size(r0_size), .r0_data(r0_data),
        .r0_grant(r0_grant), .r0_strobe(r0_strobe),
        .r0_rewind(r0_rewind), .r0_done(r0_done), .r0_error(r0_error),
        .r1_req(r1_req), .r1_size(r1_size), .r1_data(r1_data),
        .r1_grant(r1_grant), .r1_strobe(r1_strobe),
        .r1_rewind(r1_rewind), .r1_done(r1_done), .r1_error(r1_error),
        .lnk_write_start(lnk_write_start),
        .lnk_write_size(lnk_write_size),
        .lnk_write_data(lnk_write_data),
        .lnk_write_strobe(lnk_write_strobe),
        .lnk_write_finished(lnk_write_finished),
        .lnk_xmit_error(lnk_xmit_error),
        .lnk_idle(lnk_idle),
        .lnk_sync_escape(lnk_sync_escape),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_outs"},
            {20'd0, r0_grant, r0_strobe, r0_rewind, r0_done, r0_error,
             r1_grant, r1_strobe, r1_rewind, r1_done, r1_error,
             lnk_write_start, lnk_sync_escape},
            32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_size"}, lnk_write_size, 32'd0);
        chk({tag, "_data"}, lnk_write_data, 32'd0);
    endtask

    int n_strb;
    int n_start;
    int n_rew;
    int n_cyc;
    logic saw_start;

    initial begin
        // Reset state
        #2;
        chk_idle_outs("reset");
        step();
        rst = 1'b0;
        step();

        // Single frame, r0, size 4
        r0_req = 1'b1; r0_size = 32'd4; r0_data = 32'hA0A0_0000;
        step();
        chk("t1_grant", {31'd0, r0_grant}, 32'd1);
        chk("t1_r1grant", {31'd0, r1_grant}, 32'd0);
        chk("t1_start", {31'd0, lnk_write_start}, 32'd1);
        chk("t1_size", lnk_write_size, 32'd4);
        chk("t1_data", lnk_write_data, 32'hA0A0_0000);
        step();
        chk("t1_start_off", {31'd0, lnk_write_start}, 32'd0);
        n_strb = 0;
        for (int i = 0; i < 4; i++) begin
            lnk_write_strobe = 1'b1;
            #1;
            if (r0_strobe) n_strb++;
            if (r1_strobe) n_strb += 100;
            step();
        end
        lnk_write_strobe = 1'b0;
        chk("t1_strobes", n_strb, 32'd4);
        lnk_write_finished = 1'b1;
        step();
        lnk_write_finished = 1'b0;
        chk("t1_done", {31'd0, r0_done}, 32'd1);
        chk("t1_err", {31'd0, r0_error}, 32'd0);
        chk("t1_drop", {31'd0, r0_grant}, 32'd0);
        r0_req = 1'b0;
        step();
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_done_off", {31'd0, r0_done}, 32'd0);

        // Collision after reset: r0 then r1, then r0 again
        rst = 1'b1;
        step();
        rst = 1'b0;
        r0_req = 1'b1; r0_size = 32'd8; r0_data = 32'hA1;
        r1_req = 1'b1; r1_size = 32'd8; r1_data = 32'hB1;
        step();
        chk("t2_g0", {30'd0, r1_grant, r0_grant}, 32'b01);
        chk("t2_size", lnk_write_size, 32'd8);
        step();
        lnk_write_finished = 1'b1;
        step();
        lnk_write_finished = 1'b0;
        chk("t2_done0", {31'd0, r0_done}, 32'd1);
        r0_req = 1'b0;
        step();
        chk("t2_g1", {30'd0, r1_grant, r0_grant}, 32'b10);
        chk("t2_data1", lnk_write_data, 32'hB1);
        step();
        lnk_write_strobe = 1'b1;
        #1;
        chk("t2_strb", {30'd0, r1_strobe, r0_strobe}, 32'b10);
        lnk_write_strobe = 1'b0;
        lnk_write_finished = 1'b1;
        step();
        lnk_write_finished = 1'b0;
        chk("t2_done1", {31'd0, r1_done}, 32'd1);
        r1_req = 1'b0;
        step();
        r0_req = 1'b1; r1_req = 1'b1;
        step();
        chk("t2_g0_again", {30'd0, r1_grant, r0_grant}, 32'b01);
        step();
        lnk_write_finished = 1'b1;
        step();
        lnk_write_finished = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        step();

        // Illegal sizes on r1
        r1_req = 1'b1; r1_size = 32'd0;
        step();
        chk("t3_z_done", {30'd0, r1_done, r1_error}, 32'b11);
        chk("t3_z_nostart", {30'd0, lnk_write_start, r1_grant}, 32'd0);
        r1_req = 1'b0;
        step();
        chk("t3_z_busy", {31'd0, busy}, 32'd0);
        r1_req = 1'b1; r1_size = 32'd2049;
        step();
        chk("t3_big_done", {30'd0, r1_done, r1_error}, 32'b11);
        chk("t3_big_nostart", {30'd0, lnk_write_start, r1_grant}, 32'd0);
        r1_req = 1'b0;
        step();

        // Transmit errors
        r0_req = 1'b1; r0_size = 32'd4;
        n_start = 0; n_rew = 0;
        step();
        n_start += int'(lnk_write_start);
        step();
        for (int i = 0; i < 3; i++) begin
            lnk_write_finished = 1'b1; lnk_xmit_error = 1'b1;
            step();
            lnk_write_finished = 1'b0; lnk_xmit_error = 1'b0;
            n_start += int'(lnk_write_start);
            n_rew += int'(r0_rewind);
            if (r0_done) break;
            step();
        end
        chk("t4_done", {30'd0, r0_done, r0_error}, 32'b11);
`ifdef SATA_WR_ARB_RETRY_EN
        chk("t4_starts", n_start, 32'd3);
        chk("t4_rewinds", n_rew, 32'd2);
`else
        chk("t4_starts", n_start, 32'd1);
        chk("t4_rewinds", n_rew, 32'd0);
`endif
        r0_req = 1'b0;
        step();

        // Timeout escape, then wait for link idle
        r1_req = 1'b1; r1_size = 32'd16;
        step();
        chk("t5_grant", {31'd0, r1_grant}, 32'd1);
        lnk_idle = 1'b0;
        n_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            n_cyc++;
            if (lnk_sync_escape) break;
        end
        chk("t5_esc_cycle", n_cyc, 32'd101);
        step();
        step();
        chk("t5_wait", {29'd0, busy, r1_grant, r1_done}, 32'b110);
        lnk_idle = 1'b1;
        step();
        chk("t5_done", {29'd0, r1_done, r1_error, r1_grant}, 32'b110);
        r1_req = 1'b0;
        step();

        // Requester withdraws mid-frame
        r1_req = 1'b1; r1_size = 32'd4;
        step();
        step();
        r1_req = 1'b0;
        step();
        chk("t6_esc", {30'd0, lnk_sync_escape, r1_done}, 32'b10);
        step();
        chk("t6_nodone", {29'd0, busy, r1_done, r1_grant}, 32'd0);

        // Async reset mid-frame, then collision goes to r0
        r0_req = 1'b1; r0_size = 32'd4; r0_data = 32'hC0;
        step();
        step();
        lnk_write_strobe = 1'b1;
        #1;
        chk("t7_pre", {30'd0, r0_grant, r0_strobe}, 32'b11);
        #1;
        rst = 1'b1;
        #1;
        chk_idle_outs("t7_rst");
        lnk_write_strobe = 1'b0;
        r0_req = 1'b0;
        step();
        rst = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1;
        step();
        chk("t7_g0", {30'd0, r1_grant, r0_grant}, 32'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
